// File: rtl/uart_pkg.sv
// Shared types and helpers for the board-to-PC UART byte transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic int clks_per_bit(input int clk, input int baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Restartable bit-time counter; bit_tick marks the last cycle of each bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic restart,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_tick = !restart && (cnt == LAST);

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      cnt <= '0;
    end else if (restart || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_byte_tx.sv
// One-byte UART serialiser: start, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. Level-sensitive send, accepted only while idle.
module uart_byte_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [7:0] i_tx_data,
  input  logic       i_send,
  output logic       o_txd,
  output logic       o_txd_busy,
  output logic       o_tx_done
);

  import uart_pkg::*;

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_t  state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic       par, par_n;
  logic       txd_n, done_n;
  logic       restart, tick;

  // Counter is held cleared while idle, so every frame starts on a fresh bit-time.
  assign restart = (state == IDLE);

  uart_baud_gen #(.CLKS_PER_BIT(CPB)) u_baud (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .restart  (restart),
    .bit_tick (tick)
  );

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_n     = par;
    done_n    = 1'b0;
    unique case (state)
      IDLE: if (i_send) begin
        shreg_n = i_tx_data;
        par_n   = (^i_tx_data) ^ (PARITY == PAR_ODD);
        state_n = START;
      end
      START: if (tick) begin
        state_n   = DATA;
        bit_cnt_n = '0;
      end
      DATA: if (tick) begin
        if (bit_cnt == 3'd7) begin
          state_n   = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
          bit_cnt_n = '0;
        end else begin
          bit_cnt_n = bit_cnt + 3'd1;
          shreg_n   = shreg >> 1;
        end
      end
      uart_pkg::PARITY: if (tick) begin
        state_n   = STOP;
        bit_cnt_n = '0;
      end
      STOP: if (tick) begin
        if (bit_cnt == LAST_STOP) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          bit_cnt_n = bit_cnt + 3'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level is decoded from the next state so o_txd can be a plain register.
    unique case (state_n)
      START:            txd_n = 1'b0;
      DATA:             txd_n = shreg_n[0];
      uart_pkg::PARITY: txd_n = par_n;
      default:          txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      o_txd      <= 1'b1;
      o_txd_busy <= 1'b0;
      o_tx_done  <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      par        <= par_n;
      o_txd      <= txd_n;
      o_txd_busy <= (state_n != IDLE);
      o_tx_done  <= done_n;
    end
  end

endmodule
